// File: rtl/gray_seq_ctrl.sv
// Gray-code position sequencer: single steps, bounded runs and continuous runs in either direction.
// Optional pause input and PAUSED state are enabled by defining GRAY_SEQ_PAUSE_EN.
module gray_seq_ctrl #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             dir,
    input  logic             cont,
    input  logic [CNT_W-1:0] steps,
`ifdef GRAY_SEQ_PAUSE_EN
    input  logic             pause,
`endif
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
`ifdef GRAY_SEQ_PAUSE_EN
        , PAUSED
`endif
    } state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] remaining;
    logic             cont_run;

    logic             advance;
    logic             load_bounded;
    logic             load_cont;
    logic             dec_remaining;
    logic             wraps;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_next;

    always_comb begin
        bin_next  = dir ? bin - 1'b1 : bin + 1'b1;
        gray_next = bin_next ^ (bin_next >> 1);
        wraps     = dir ? (bin == '0) : (bin == '1);
    end

    always_comb begin
        next_state    = state;
        advance       = 1'b0;
        load_bounded  = 1'b0;
        load_cont     = 1'b0;
        dec_remaining = 1'b0;
        case (state)
            IDLE: begin
                // start wins over step even when a zero-length start is ignored
                if (start) begin
                    if (cont) begin
                        load_cont  = 1'b1;
                        next_state = RUN;
                    end else if (steps != '0) begin
                        load_bounded = 1'b1;
                        next_state   = RUN;
                    end
                end else if (step) begin
                    advance = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    next_state = IDLE;
`ifdef GRAY_SEQ_PAUSE_EN
                end else if (pause) begin
                    next_state = PAUSED;
`endif
                end else begin
                    advance = 1'b1;
                    if (!cont_run) begin
                        dec_remaining = 1'b1;
                        if (remaining == CNT_W'(1)) begin
                            next_state = DONE;
                        end
                    end
                end
            end
            DONE: begin
                next_state = IDLE;
            end
`ifdef GRAY_SEQ_PAUSE_EN
            PAUSED: begin
                if (stop) begin
                    next_state = IDLE;
                end else if (!pause) begin
                    next_state = RUN;
                end
            end
`endif
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bin       <= '0;
            gray      <= '0;
            remaining <= '0;
            cont_run  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            bin       <= '0;
            gray      <= '0;
            remaining <= '0;
            cont_run  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state <= next_state;
            if (advance) begin
                bin  <= bin_next;
                gray <= gray_next;
            end
            wrap <= advance && wraps;
`ifdef GRAY_SEQ_PAUSE_EN
            busy <= (next_state == RUN) || (next_state == PAUSED);
`else
            busy <= (next_state == RUN);
`endif
            // done trails the DONE state by one edge so it lands one cycle after the last advance
            done <= (state == DONE);
            if (load_bounded) begin
                remaining <= steps;
                cont_run  <= 1'b0;
            end else if (load_cont) begin
                cont_run  <= 1'b1;
            end else if (dec_remaining) begin
                remaining <= remaining - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Directed self-checking bench for gray_seq_ctrl (WIDTH=3, CNT_W=8).
module tb_gray_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset, clear, start, stop, step, dir, cont;
    logic [7:0] steps;
`ifdef GRAY_SEQ_PAUSE_EN
    logic       pause;
`endif
    logic [2:0] gray, bin;
    logic       busy, done, wrap;

    int n_checks = 0;
    int n_fail   = 0;

    gray_seq_ctrl #(.WIDTH(3), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .clear(clear), .start(start), .stop(stop),
        .step(step), .dir(dir), .cont(cont), .steps(steps),
`ifdef GRAY_SEQ_PAUSE_EN
        .pause(pause),
`endif
        .gray(gray), .bin(bin), .busy(busy), .done(done), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [2:0] g, input logic [2:0] b,
                           input logic bz, input logic dn, input logic wr);
        chk({tag, ".gray"}, 8'(gray), 8'(g));
        chk({tag, ".bin"},  8'(bin),  8'(b));
        chk({tag, ".busy"}, 8'(busy), 8'(bz));
        chk({tag, ".done"}, 8'(done), 8'(dn));
        chk({tag, ".wrap"}, 8'(wrap), 8'(wr));
    endtask

    logic [2:0] up_gray [8];
    logic [2:0] up_bin  [8];

    initial begin
        up_gray = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        up_bin  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        reset = 1'b1; clear = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;
        dir = 1'b0; cont = 1'b0; steps = '0;
`ifdef GRAY_SEQ_PAUSE_EN
        pause = 1'b0;
`endif
        #12;
        chk_out("reset", 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();

        // bounded run of 8 upward
        start = 1'b1; steps = 8'd8; dir = 1'b0;
        tick();
        start = 1'b0;
        chk_out("run8_accept", 3'b000, 3'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_out($sformatf("run8_adv%0d", i), up_gray[i], up_bin[i], i < 7, 1'b0, i == 7);
        end
        tick();
        chk_out("run8_done", 3'b000, 3'd0, 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("run8_after", 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);

        // single steps downward
        step = 1'b1; dir = 1'b1;
        tick();
        step = 1'b0;
        chk_out("step_dn1", 3'b100, 3'd7, 1'b0, 1'b0, 1'b1);
        step = 1'b1;
        tick();
        step = 1'b0;
        chk_out("step_dn2", 3'b101, 3'd6, 1'b0, 1'b0, 1'b0);

        // continuous run, stopped after 5 advances
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk_out("clear1", 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b1; cont = 1'b1; dir = 1'b0;
        tick();
        start = 1'b0; cont = 1'b0;
        repeat (4) begin
            tick();
            chk("cont_done_low", 8'(done), 8'd0);
        end
        tick();
        chk_out("cont_5adv", 3'b111, 3'd5, 1'b1, 1'b0, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_out("cont_stop", 3'b111, 3'd5, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("cont_idle", 3'b111, 3'd5, 1'b0, 1'b0, 1'b0);

        // zero-length start is ignored
        start = 1'b1; steps = 8'd0;
        tick();
        start = 1'b0;
        chk_out("zero_start", 3'b111, 3'd5, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("zero_after", 3'b111, 3'd5, 1'b0, 1'b0, 1'b0);

        // start together with step: run starts, no advance in that cycle
        start = 1'b1; step = 1'b1; steps = 8'd2; dir = 1'b0;
        tick();
        start = 1'b0; step = 1'b0;
        chk_out("start_step", 3'b111, 3'd5, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("ss_adv1", 3'b101, 3'd6, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("ss_adv2", 3'b100, 3'd7, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("ss_done", 3'b100, 3'd7, 1'b0, 1'b1, 1'b0);

        // clear mid bounded run
        clear = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b1; steps = 8'd6; dir = 1'b0;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk_out("clr_mid", 3'b010, 3'd3, 1'b1, 1'b0, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk_out("clr_hit", 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);
        repeat (4) begin
            tick();
            chk_out("clr_idle", 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);
        end

        // asynchronous reset mid run
        start = 1'b1; steps = 8'd6;
        tick();
        start = 1'b0;
        repeat (2) tick();
        chk_out("rst_mid", 3'b011, 3'd2, 1'b1, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk_out("rst_async", 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);
        #1 reset = 1'b0;
        tick();
        chk_out("rst_after", 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);

`ifdef GRAY_SEQ_PAUSE_EN
        start = 1'b1; steps = 8'd4; dir = 1'b0;
        tick();
        start = 1'b0;
        repeat (2) tick();
        chk_out("pz_2adv", 3'b011, 3'd2, 1'b1, 1'b0, 1'b0);
        pause = 1'b1;
        repeat (3) begin
            tick();
            chk_out("pz_hold", 3'b011, 3'd2, 1'b1, 1'b0, 1'b0);
        end
        pause = 1'b0;
        tick();
        chk_out("pz_resume", 3'b011, 3'd2, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("pz_adv3", 3'b010, 3'd3, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("pz_adv4", 3'b110, 3'd4, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("pz_done", 3'b110, 3'd4, 1'b0, 1'b1, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_seq_ctrl.md
Name: gray_seq_ctrl

Overview:
- Sequencer that owns and drives a WIDTH-bit Gray-code position register.
- Supports three motions in either direction: single steps, bounded runs of N steps, and continuous runs until stopped.
- Reports busy, done and wrap status.
- Sits between control logic (FSMs, button debouncers) and any consumer of a single-bit-change position code, e.g. encoders, pointer sync, LED sequences.

Parameters:
- WIDTH, 3, position width in bits; Gray sequence length 2^WIDTH.
- CNT_W, 8, width of the step-count input and the internal remaining-steps counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous: position to 0, state to IDLE.
- start  input  1  begin a run; sampled in IDLE only.
- stop  input  1  abort a run; sampled in RUN only.
- step  input  1  single advance; sampled in IDLE only.
- dir  input  1  0 = up (000,001,011,010,110,111,101,100 for WIDTH=3), 1 = down; sampled on every advance.
- cont  input  1  with start: run until stop, steps ignored.
- steps  input  CNT_W  number of advances for a bounded run; sampled with start.
- gray  output  WIDTH  current Gray position, registered.
- bin  output  WIDTH  binary equivalent of gray, registered.
- busy  output  1  high while state is RUN (or PAUSED).
- done  output  1  one-cycle pulse when a bounded run completes.
- wrap  output  1  one-cycle pulse in the cycle gray shows a wrapped value.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset values: state IDLE, bin=0, gray=0, busy=0, done=0, wrap=0, remaining=0.
- Encoding: internal binary counter; gray = bin ^ (bin >> 1), computed from the next binary value and registered alongside it, so gray and bin are always consistent.
- Up advance: bin+1 mod 2^WIDTH. Down advance: bin-1 mod 2^WIDTH.
- wrap: set on the edge where bin goes max->0 (up) or 0->max (down); otherwise 0.
- Priority: reset > clear > state logic. clear in any state: bin=0, gray=0, state IDLE, remaining=0, done=0, wrap=0. An interrupted run does not assert done.
- IDLE:
  - start=1 and cont=1 -> RUN (continuous).
  - start=1, cont=0, steps!=0 -> load remaining=steps, go to RUN.
  - start=1, cont=0, steps=0 -> ignored; no state change, no done.
  - start=1 has priority over step; no advance occurs in the start cycle.
  - step=1 (start=0) -> advance once, stay IDLE, wrap as applicable, busy stays 0.
- RUN:
  - stop=1 -> no advance, go to IDLE next cycle, no done.
  - Otherwise advance one position per cycle.
  - Bounded run: decrement remaining; the advance with remaining=1 is the last, and state goes to DONE. Exactly steps advances occur, the first on the cycle after start.
  - Continuous run: remaining untouched.
  - step and start are ignored in RUN.
- DONE: single cycle with done=1, busy=0, no advance; start/step ignored; return to IDLE.
- busy: registered; 1 from the cycle after an accepted start through the cycle of the last advance.
- Latency: start accepted at edge k; first position change visible after edge k+1; done visible after edge k+steps+1.
- Reset asserted mid-run: immediate return to reset values.

Optional Feature:
- Macro: GRAY_SEQ_PAUSE_EN.
- Defined:
  - Adds input pause (1 bit) and state PAUSED.
  - In RUN, pause=1 -> PAUSED with no advance; remaining and position frozen; busy stays 1.
  - In PAUSED, pause=0 -> RUN, resuming advances the next cycle.
  - stop in PAUSED -> IDLE with no done.
  - clear and reset behave as in all other states.
- Undefined: no pause port and no PAUSED state; behaviour exactly as above.

Test Plan:
- Reset, then start=1, cont=0, steps=8, dir=0 -> gray 001,011,010,110,111,101,100,000 on 8 consecutive cycles; wrap=1 with 000; done=1 one cycle later; busy=0 after.
- From gray=000 in IDLE, step=1 with dir=1 -> gray=100, bin=7, wrap=1, busy=0; second step -> gray=101, wrap=0.
- start, cont=1, dir=0; after 5 advances assert stop -> gray=111, state IDLE, done never asserted.
- start with steps=0, cont=0 -> no state change, busy=0, done=0; start and step together in IDLE -> run starts, no advance in that cycle.
- Mid bounded run (steps=6, after 3 advances) assert clear -> gray=000, bin=0, busy=0, no done; then assert reset asynchronously between edges -> all outputs 0 immediately.
- With GRAY_SEQ_PAUSE_EN: steps=4, pause 3 cycles after the 2nd advance -> gray holds 011 with busy=1; after release, 2 more advances to 110 and done=1.
